// File: rtl/mem_bus_arbiter.sv
// Two-core round-robin arbiter for a shared main-memory port, with a
// per-transaction timeout that releases the bus if memory never answers.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_last_served, w_last_served_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_gnt0, w_gnt0_nxt;
    logic          r_gnt1, w_gnt1_nxt;
    logic          r_ack0, w_ack0_nxt;
    logic          r_ack1, w_ack1_nxt;
    logic          r_err, w_err_nxt;
    logic [31:0]   r_rdata, w_rdata_nxt;
    logic          r_mem_req, w_mem_req_nxt;
    logic          r_mem_we, w_mem_we_nxt;
    logic [31:0]   r_mem_addr, w_mem_addr_nxt;
    logic [31:0]   r_mem_wdata, w_mem_wdata_nxt;

    logic w_elig0, w_elig1, w_pick;

    // A core that is seeing its own ack/err this cycle still holds a stale req
    assign w_elig0 = req0 & ~r_ack0 & ~(r_err & ~r_owner);
    assign w_elig1 = req1 & ~r_ack1 & ~(r_err & r_owner);
    assign w_pick  = (w_elig0 & w_elig1) ? ~r_last_served : w_elig1;

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt       = r_state;
        w_owner_nxt       = r_owner;
        w_last_served_nxt = r_last_served;
        w_cnt_nxt         = r_cnt;
        w_gnt0_nxt        = 1'b0;
        w_gnt1_nxt        = 1'b0;
        w_ack0_nxt        = 1'b0;
        w_ack1_nxt        = 1'b0;
        w_err_nxt         = 1'b0;
        w_rdata_nxt       = r_rdata;
        w_mem_req_nxt     = 1'b0;
        w_mem_we_nxt      = r_mem_we;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wdata_nxt   = r_mem_wdata;
        case (r_state)
            IDLE: begin
                if (w_elig0 | w_elig1) begin
                    w_state_nxt     = BUSY;
                    w_owner_nxt     = w_pick;
                    w_cnt_nxt       = {CW{1'b0}};
                    w_gnt0_nxt      = ~w_pick;
                    w_gnt1_nxt      = w_pick;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = w_pick ? we1 : we0;
                    w_mem_addr_nxt  = w_pick ? addr1 : addr0;
                    w_mem_wdata_nxt = w_pick ? wdata1 : wdata0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    w_state_nxt       = IDLE;
                    w_ack0_nxt        = ~r_owner;
                    w_ack1_nxt        = r_owner;
                    w_rdata_nxt       = mem_rdata;
                    w_last_served_nxt = r_owner;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt       = IDLE;
                    w_err_nxt         = 1'b1;
                    w_last_served_nxt = r_owner;
                end else begin
                    w_cnt_nxt     = r_cnt + CW'(1);
                    w_gnt0_nxt    = ~r_owner;
                    w_gnt1_nxt    = r_owner;
                    w_mem_req_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_last_served <= 1'b1;
            r_cnt         <= {CW{1'b0}};
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_err         <= 1'b0;
            r_rdata       <= 32'h0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 32'h0;
            r_mem_wdata   <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_last_served <= w_last_served_nxt;
            r_cnt         <= w_cnt_nxt;
            r_gnt0        <= w_gnt0_nxt;
            r_gnt1        <= w_gnt1_nxt;
            r_ack0        <= w_ack0_nxt;
            r_ack1        <= w_ack1_nxt;
            r_err         <= w_err_nxt;
            r_rdata       <= w_rdata_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter: completions are queued as they are
// stimulated and matched by a monitor that also checks bus invariants.
module tb_mem_bus_arbiter;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, ack0, ack1, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        core;
        logic        is_err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_gnt0 = 1'b0;
    logic prev_gnt1 = 1'b0;

    mem_bus_arbiter #(.TIMEOUT(TB_TIMEOUT)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .err(err),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Invariant checks and scoreboard matching on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                n_checks++;
                if (gnt0 && gnt1) begin
                    n_fail++;
                    $display("FAIL gnt_onehot: gnt0=%b gnt1=%b, required not both", gnt0, gnt1);
                end
                n_checks++;
                if (mem_req !== (gnt0 | gnt1)) begin
                    n_fail++;
                    $display("FAIL mem_req_eq_gnt: mem_req=%b, required %b", mem_req, gnt0 | gnt1);
                end
                n_checks++;
                if ((32'(ack0) + 32'(ack1) + 32'(err)) > 32'd1) begin
                    n_fail++;
                    $display("FAIL done_excl: ack0=%b ack1=%b err=%b, required at most one", ack0, ack1, err);
                end
                if (ack0 || ack1 || err) begin
                    n_checks++;
                    if ((ack0 && !prev_gnt0) || (ack1 && !prev_gnt1) || (err && !(prev_gnt0 || prev_gnt1))) begin
                        n_fail++;
                        $display("FAIL done_after_gnt: ack0=%b ack1=%b err=%b prev_gnt=%b%b, required matching prior gnt",
                                 ack0, ack1, err, prev_gnt0, prev_gnt1);
                    end
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: ack0=%b ack1=%b err=%b, required no completion", ack0, ack1, err);
                    end else begin
                        e = sb.pop_front();
                        if (e.is_err) begin
                            if (!err || ack0 || ack1) begin
                                n_fail++;
                                $display("FAIL sb_err: ack0=%b ack1=%b err=%b, required err for core %0d", ack0, ack1, err, e.core);
                            end
                        end else if ((e.core ? ack1 : ack0) !== 1'b1 || err || rdata !== e.rdata) begin
                            n_fail++;
                            $display("FAIL sb_ack: ack0=%b ack1=%b err=%b rdata=%h, required ack core %0d rdata=%h",
                                     ack0, ack1, err, rdata, e.core, e.rdata);
                        end
                    end
                end
            end
            prev_gnt0 = gnt0;
            prev_gnt1 = gnt1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        n_checks++;
        if ({gnt0, gnt1, ack0, ack1, err, mem_req, mem_we} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt=%b%b ack=%b%b err=%b mem_req=%b mem_we=%b, required all 0",
                     gnt0, gnt1, ack0, ack1, err, mem_req, mem_we);
        end
        n_checks++;
        if (rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h, required 0", rdata, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100; wdata0 = 32'h7777;
        tick();
        n_checks++;
        if ({gnt0, gnt1, mem_req, mem_we} !== 4'b1010 || mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL read_grant: gnt=%b%b mem_req=%b mem_we=%b mem_addr=%h, required 1 0 1 0 00000100",
                     gnt0, gnt1, mem_req, mem_we, mem_addr);
        end
        tick();
        tick();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        sb.push_back('{1'b0, 1'b0, 32'hDEAD_BEEF});
        tick();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        n_checks++;
        if ({ack0, ack1, err, mem_req, gnt0} !== 5'b10000 || rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL read_ack: ack=%b%b err=%b mem_req=%b gnt0=%b rdata=%h, required 1 0 0 0 0 deadbeef",
                     ack0, ack1, err, mem_req, gnt0, rdata);
        end
        tick();
        n_checks++;
        if ({gnt0, gnt1, mem_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL stale_req: gnt=%b%b mem_req=%b, required 000", gnt0, gnt1, mem_req);
        end
        req0 = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ready = 1'b0;
        tick();
        n_checks++;
        if ({ack0, ack1, gnt0, gnt1} !== 4'b0000 || rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL idle_ready: ack=%b%b gnt=%b%b rdata=%h, required 0000 deadbeef", ack0, ack1, gnt0, gnt1, rdata);
        end
    endtask

    task automatic test_round_robin();
        logic        exp_owner;
        logic        found;
        logic [31:0] d;
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h1000; addr1 = 32'h2000;
        exp_owner = 1'b0;
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            for (int k = 0; k < 8 && !found; k++) begin
                tick();
                if (gnt0 || gnt1) found = 1'b1;
            end
            n_checks++;
            if (!found) begin
                n_fail++;
                $display("FAIL rr_wait: no grant for turn %0d, required grant within 8 cycles", i);
                break;
            end
            n_checks++;
            if (gnt0 !== (exp_owner == 1'b0) || gnt1 !== (exp_owner == 1'b1) ||
                mem_addr !== (exp_owner ? 32'h2000 : 32'h1000)) begin
                n_fail++;
                $display("FAIL rr_order: turn %0d gnt=%b%b mem_addr=%h, required owner %0d", i, gnt0, gnt1, mem_addr, exp_owner);
            end
            d = 32'hA000_0000 + 32'(i);
            mem_ready = 1'b1; mem_rdata = d;
            sb.push_back('{exp_owner, 1'b0, d});
            tick();
            mem_ready = 1'b0;
            n_checks++;
            if ({ack0, ack1} !== (exp_owner ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL rr_ack: turn %0d ack=%b%b, required owner %0d", i, ack0, ack1, exp_owner);
            end
            exp_owner = ~exp_owner;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_write_hold();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h55AA;
        tick();
        n_checks++;
        if ({gnt0, gnt1, mem_req, mem_we} !== 4'b0111 || mem_addr !== 32'h40 || mem_wdata !== 32'h55AA) begin
            n_fail++;
            $display("FAIL wr_grant: gnt=%b%b mem_req=%b mem_we=%b addr=%h wdata=%h, required 0 1 1 1 40 55aa",
                     gnt0, gnt1, mem_req, mem_we, mem_addr, mem_wdata);
        end
        addr1 = 32'h80; wdata1 = 32'hFFFF; we1 = 1'b0; req1 = 1'b0;
        tick();
        n_checks++;
        if ({gnt1, mem_req, mem_we} !== 3'b111 || mem_addr !== 32'h40 || mem_wdata !== 32'h55AA) begin
            n_fail++;
            $display("FAIL wr_hold: gnt1=%b mem_req=%b mem_we=%b addr=%h wdata=%h, required 1 1 1 40 55aa",
                     gnt1, mem_req, mem_we, mem_addr, mem_wdata);
        end
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        sb.push_back('{1'b1, 1'b0, 32'h1234_5678});
        tick();
        mem_ready = 1'b0;
        n_checks++;
        if ({ack1, ack0, err} !== 3'b100 || rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL wr_ack: ack1=%b ack0=%b err=%b rdata=%h, required 1 0 0 12345678", ack1, ack0, err, rdata);
        end
        tick();
    endtask

    task automatic test_timeout();
        req0 = 1'b1; addr0 = 32'h300; req1 = 1'b1; addr1 = 32'h340;
        tick();
        n_checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_fail++;
            $display("FAIL to_grant: gnt=%b%b, required 10", gnt0, gnt1);
        end
        sb.push_back('{1'b0, 1'b1, 32'h0});
        for (int k = 1; k < TB_TIMEOUT; k++) begin
            tick();
            n_checks++;
            if ({gnt0, err, ack0} !== 3'b100) begin
                n_fail++;
                $display("FAIL to_wait: cycle %0d gnt0=%b err=%b ack0=%b, required 1 0 0", k, gnt0, err, ack0);
            end
        end
        tick();
        n_checks++;
        if ({err, ack0, gnt0, mem_req} !== 4'b1000 || rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL to_err: err=%b ack0=%b gnt0=%b mem_req=%b rdata=%h, required 1 0 0 0 12345678",
                     err, ack0, gnt0, mem_req, rdata);
        end
        req0 = 1'b0;
        tick();
        n_checks++;
        if ({gnt0, gnt1} !== 2'b01 || mem_addr !== 32'h340) begin
            n_fail++;
            $display("FAIL to_next: gnt=%b%b mem_addr=%h, required 01 340", gnt0, gnt1, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
        sb.push_back('{1'b1, 1'b0, 32'hCAFE_0001});
        tick();
        mem_ready = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_timeout_race();
        req0 = 1'b1; addr0 = 32'h400;
        tick();
        for (int k = 1; k < TB_TIMEOUT; k++) tick();
        mem_ready = 1'b1; mem_rdata = 32'hBEEF_0003;
        sb.push_back('{1'b0, 1'b0, 32'hBEEF_0003});
        tick();
        mem_ready = 1'b0; req0 = 1'b0;
        n_checks++;
        if ({ack0, err} !== 2'b10 || rdata !== 32'hBEEF_0003) begin
            n_fail++;
            $display("FAIL to_race: ack0=%b err=%b rdata=%h, required 1 0 beef0003", ack0, err, rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; addr0 = 32'h500; wdata0 = 32'h99;
        tick();
        n_checks++;
        if (gnt0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_grant: gnt0=%b, required 1", gnt0);
        end
        tick();
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        n_checks++;
        if ({gnt0, gnt1, ack0, ack1, err, mem_req, mem_we} !== 7'b0 ||
            rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_clear: gnt=%b%b ack=%b%b err=%b mem_req=%b rdata=%h addr=%h, required all 0",
                     gnt0, gnt1, ack0, ack1, err, mem_req, rdata, mem_addr);
        end
        reset = 1'b0; req0 = 1'b0; mem_ready = 1'b0;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n_checks++;
        if ({ack0, ack1, err, gnt0, gnt1} !== 5'b0) begin
            n_fail++;
            $display("FAIL rm_after: ack=%b%b err=%b gnt=%b%b, required 00000", ack0, ack1, err, gnt0, gnt1);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_hold();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d completions outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles in BUSY waiting for mem_ready (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1  core 0/1 cache controller request, held until that core's ack or err.
REQ-005 SHALL have ports we0/we1  input  1  core 0/1 write enable (1 = write, 0 = read).
REQ-006 SHALL have ports addr0/addr1  input  32  core 0/1 word address.
REQ-007 SHALL have ports wdata0/wdata1  input  32  core 0/1 write data.
REQ-008 SHALL have ports gnt0/gnt1  output  1  core 0/1 owns the memory bus.
REQ-009 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse to core 0/1.
REQ-010 SHALL have port err  output  1  one-cycle timeout pulse, applying to the current owner.
REQ-011 SHALL have port rdata  output  32  read data, valid in the cycle ack0 or ack1 is high.
REQ-012 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  32, mem_wdata  output  32  shared main-memory request.
REQ-013 SHALL have ports mem_ready  input  1, mem_rdata  input  32  memory completion and read data.

Function
REQ-014 SHALL implement an FSM with states IDLE and BUSY, plus an owner bit, a last_served bit and a timeout counter of ceil(log2(TIMEOUT+1)) bits.
REQ-015 In IDLE with exactly one eligible request, SHALL grant that requester; with both eligible, SHALL grant the requester != last_served (round-robin).
REQ-016 A request is eligible only if that core's ack and err outputs are both low in the current cycle; this prevents regrant on a stale req.
REQ-017 A grant decision in cycle N SHALL give, in cycle N+1: state BUSY, gnt<owner>=1, mem_req=1, and mem_we/mem_addr/mem_wdata registered from the owner's inputs sampled in cycle N.
REQ-018 SHALL hold mem_we/mem_addr/mem_wdata constant throughout BUSY, regardless of requester input changes.
REQ-019 In BUSY, mem_ready=1 in cycle M SHALL give, in cycle M+1: ack<owner>=1, rdata=mem_rdata sampled in M, state IDLE, gnt=0, mem_req=0, last_served=owner.
REQ-020 rdata SHALL hold its last value when no ack is high; writes SHALL also update rdata (don't-care content, but deterministic).
REQ-021 The counter SHALL clear on entry to BUSY and increment each BUSY cycle with mem_ready=0.
REQ-022 If the counter equals TIMEOUT-1 and mem_ready=0, the next cycle SHALL give err=1, no ack, state IDLE, mem_req=0, last_served=owner; mem_ready=1 in that same cycle wins (normal ack).
REQ-023 The owner deasserting req during BUSY SHALL NOT abort the transaction.
REQ-024 mem_ready while IDLE SHALL be ignored.
REQ-025 gnt0 and gnt1 SHALL never be high simultaneously; ack0/ack1/err are mutually exclusive.
REQ-026 Minimum spacing between consecutive grants SHALL be one IDLE cycle (the ack/err cycle).

Reset
REQ-027 While reset=1 at a rising edge: state IDLE, last_served=1 (core 0 wins first tie), counter 0, all outputs 0 including rdata, mem_addr and mem_wdata.
REQ-028 Reset during BUSY SHALL abort the transaction with no ack or err; the first grant is possible in the cycle after reset is released.

Verification
REQ-029 Single read: req0=1, we0=0, addr0=0x100 at cycle 1 -> cycle 2 gnt0=1, mem_req=1, mem_addr=0x100; mem_ready=1, mem_rdata=0xDEADBEEF at cycle 4 -> cycle 5 ack0=1, rdata=0xDEADBEEF, mem_req=0.
REQ-030 Tie after reset: req0=req1=1 held -> core 0 granted first; after ack0 and re-request, core 1 granted next; grants alternate 0,1,0,1 while both hold req.
REQ-031 Write hold: req1=1, we1=1, addr1=0x40, wdata1=0x55AA; change addr1 to 0x80 during BUSY -> mem_addr stays 0x40 and mem_wdata stays 0x55AA until ack1.
REQ-032 Timeout: TIMEOUT=4, mem_ready held 0 -> err=1 exactly 4 cycles after gnt0 first rises, then no ack0; a pending req1 is granted next.
REQ-033 Reset mid-transaction: assert reset in the 2nd BUSY cycle -> next cycle all outputs 0, no ack; mem_ready=1 one cycle after reset release with no req -> no ack.
REQ-034 Continuous-run property checks: gnt one-hot-or-zero, mem_req==(gnt0|gnt1), and every ack or err preceded by a matching gnt.
